// File: rtl/xbar_router.sv
// xbar_router: per-source FIFOs feeding a round-robin crossbar to NUM_DST banks.
// Ports: clock, reset (sync, active-high), in_valid/in_index/in_data (per source),
// busy (backpressure), out_valid/out_index/out_data (per destination, registered).
// Option: define XBAR_DRAIN_BUSY_EN to hold busy high until the crossbar drains.
module xbar_router #(
  parameter int NUM_SRC    = 4,
  parameter int NUM_DST    = 4,
  parameter int INDEX_W    = 8,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         in_valid,
  input  logic [NUM_SRC*INDEX_W-1:0] in_index,
  input  logic [NUM_SRC*DATA_W-1:0]  in_data,
  output logic                       busy,
  output logic [NUM_DST-1:0]         out_valid,
  output logic [NUM_DST*INDEX_W-1:0] out_index,
  output logic [NUM_DST*DATA_W-1:0]  out_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int DW = (NUM_DST > 1) ? $clog2(NUM_DST) : 1;
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [INDEX_W-1:0] mem_idx [NUM_SRC][FIFO_DEPTH];
  logic [DATA_W-1:0]  mem_dat [NUM_SRC][FIFO_DEPTH];
  logic [PW-1:0]      rd_ptr  [NUM_SRC];
  logic [PW-1:0]      wt_ptr  [NUM_SRC];
  logic [SW-1:0]      rr      [NUM_DST];

  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] wr;
  logic [NUM_DST-1:0] gnt;
  logic [SW-1:0]      gnt_src [NUM_DST];
  logic [INDEX_W-1:0] h_idx   [NUM_SRC];
  logic [DATA_W-1:0]  h_dat   [NUM_SRC];

  function automatic logic maps_to(
    input logic [INDEX_W-1:0] idx,
    input int                 d
  );
    if (NUM_DST == 1) return 1'b1;
    return idx[DW-1:0] == DW'(d);
  endfunction

  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      empty[s] = rd_ptr[s] == wt_ptr[s];
      full[s]  = (rd_ptr[s][AW-1:0] == wt_ptr[s][AW-1:0]) &&
                 (rd_ptr[s][AW] != wt_ptr[s][AW]);
      h_idx[s] = mem_idx[s][rd_ptr[s][AW-1:0]];
      h_dat[s] = mem_dat[s][rd_ptr[s][AW-1:0]];
    end
  end

`ifdef XBAR_DRAIN_BUSY_EN
  assign busy = (|full) | (~&empty) | (|out_valid);
`else
  assign busy = |full;
`endif

  // A whole batch is either accepted or dropped.
  assign wr = busy ? '0 : in_valid;

  // Round-robin scan per bank; a head maps to one bank, so pops never collide.
  always_comb begin
    int c;
    c   = 0;
    gnt = '0;
    pop = '0;
    for (int d = 0; d < NUM_DST; d++) gnt_src[d] = '0;
    for (int d = 0; d < NUM_DST; d++) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        c = int'(rr[d]) + k;
        if (c >= NUM_SRC) c = c - NUM_SRC;
        if (!gnt[d] && !empty[SW'(c)] && maps_to(h_idx[SW'(c)], d)) begin
          gnt[d]     = 1'b1;
          gnt_src[d] = SW'(c);
        end
      end
    end
    for (int d = 0; d < NUM_DST; d++) begin
      if (gnt[d]) pop[gnt_src[d]] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    for (int s = 0; s < NUM_SRC; s++) begin
      if (!reset && wr[s]) begin
        mem_idx[s][wt_ptr[s][AW-1:0]] <= in_index[s*INDEX_W +: INDEX_W];
        mem_dat[s][wt_ptr[s][AW-1:0]] <= in_data[s*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        rd_ptr[s] <= '0;
        wt_ptr[s] <= '0;
      end
      for (int d = 0; d < NUM_DST; d++) rr[d] <= '0;
      out_valid <= '0;
      out_index <= '0;
      out_data  <= '0;
    end else begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (wr[s])  wt_ptr[s] <= wt_ptr[s] + PW'(1);
        if (pop[s]) rd_ptr[s] <= rd_ptr[s] + PW'(1);
      end
      for (int d = 0; d < NUM_DST; d++) begin
        out_valid[d] <= gnt[d];
        if (gnt[d]) begin
          out_index[d*INDEX_W +: INDEX_W] <= h_idx[gnt_src[d]];
          out_data[d*DATA_W +: DATA_W]    <= h_dat[gnt_src[d]];
          rr[d] <= (gnt_src[d] == SW'(NUM_SRC - 1)) ?
                   '0 : gnt_src[d] + SW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_xbar_router.sv
// tb_xbar_router: directed-vector bench for xbar_router.
// Expectations follow XBAR_DRAIN_BUSY_EN when it is defined.
module tb_xbar_router;

`ifdef XBAR_DRAIN_BUSY_EN
  localparam bit DRAIN = 1'b1;
`else
  localparam bit DRAIN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  in_valid = '0;
  logic [31:0] in_index = '0;
  logic [63:0] in_data  = '0;
  logic        busy;
  logic [3:0]  out_valid;
  logic [31:0] out_index;
  logic [63:0] out_data;

  int n_chk = 0;
  int n_bad = 0;

  xbar_router dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_index  (in_index),
    .in_data   (in_data),
    .busy      (busy),
    .out_valid (out_valid),
    .out_index (out_index),
    .out_data  (out_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input int s, input logic [7:0] idx,
                     input logic [15:0] dat);
    in_valid[s]          = 1'b1;
    in_index[s*8 +: 8]   = idx;
    in_data[s*16 +: 16]  = dat;
  endtask

  task automatic do_reset();
    in_valid = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [15:0] dat_of(input int d);
    return out_data[d*16 +: 16];
  endfunction

  function automatic logic [7:0] idx_of(input int d);
    return out_index[d*8 +: 8];
  endfunction

  initial begin
    int cnt;
    int exp_src;

    // Reset
    do_reset();
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_busy",  64'(busy), 64'h0);
    chk("rst_data",  out_data, 64'h0);
    chk("rst_index", 64'(out_index), 64'h0);

    // Conflict-free: one packet per bank
    for (int s = 0; s < 4; s++) put(s, 8'(s), 16'(10 * (s + 1)));
    tick();
    in_valid = '0;
    chk("cf_lat_valid", 64'(out_valid), 64'h0);
    chk("cf_lat_busy",  64'(busy), 64'(DRAIN));
    tick();
    chk("cf_valid", 64'(out_valid), 64'hf);
    chk("cf_busy",  64'(busy), 64'(DRAIN));
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("cf_data%0d", d), 64'(dat_of(d)), 64'(10 * (d + 1)));
      chk($sformatf("cf_idx%0d", d), 64'(idx_of(d)), 64'(d));
    end
    tick();
    chk("cf_once",  64'(out_valid), 64'h0);
    chk("cf_hold",  64'(dat_of(2)), 64'd30);
    chk("cf_idle_busy", 64'(busy), 64'h0);

    // Full conflict on bank 0
    do_reset();
    for (int s = 0; s < 4; s++) put(s, 8'd4, 16'(s + 1));
    tick();
    in_valid = '0;
    chk("fc_busy0", 64'(busy), 64'(DRAIN));
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("fc_valid%0d", k), 64'(out_valid), 64'h1);
      chk($sformatf("fc_data%0d", k), 64'(dat_of(0)), 64'(k));
      chk($sformatf("fc_idx%0d", k), 64'(idx_of(0)), 64'd4);
      chk($sformatf("fc_busy%0d", k), 64'(busy), 64'(DRAIN));
    end
    tick();
    chk("fc_end_valid", 64'(out_valid), 64'h0);
    chk("fc_end_busy",  64'(busy), 64'h0);
    // rr[0] back at 0: source 0 must beat source 3
    put(0, 8'd4, 16'd100);
    put(3, 8'd4, 16'd103);
    tick();
    in_valid = '0;
    tick();
    chk("fc_rr_first", 64'(dat_of(0)), 64'd100);
    tick();
    chk("fc_rr_second", 64'(dat_of(0)), 64'd103);

    // Round-robin fairness on bank 3
    do_reset();
    cnt = 0;
    exp_src = 1;
    for (int e = 0; e < 14; e++) begin
      in_valid = '0;
      if (e < 6) begin
        put(1, 8'd3, 16'h0100);
        put(2, 8'd7, 16'h0200);
      end
      tick();
      chk($sformatf("rr_other%0d", e), 64'(out_valid[2:0]), 64'h0);
      if (out_valid[3]) begin
        chk($sformatf("rr_src%0d", e), 64'(dat_of(3) >> 8), 64'(exp_src));
        exp_src = (exp_src == 1) ? 2 : 1;
        cnt++;
      end
    end
    in_valid = '0;
    chk("rr_count", 64'(cnt), DRAIN ? 64'd4 : 64'd12);

`ifndef XBAR_DRAIN_BUSY_EN
    // Backpressure: FIFO 0 fills while bank 1 is contended
    do_reset();
    put(0, 8'd1, 16'haaaa);
    tick();
    in_valid = '0;
    tick();
    chk("bp_pre", 64'(dat_of(1)), 64'haaaa);
    for (int k = 0; k <= 17; k++) begin
      in_valid = '0;
      if (k <= 4) begin
        for (int s = 0; s < 4; s++) put(s, 8'd1, 16'((s << 8) | k));
        if (k == 4) put(3, 8'd1, 16'hdead);
      end
      tick();
      chk($sformatf("bp_busy%0d", k), 64'(busy), 64'(k == 3));
      if (k >= 1 && k <= 16) begin
        chk($sformatf("bp_valid%0d", k), 64'(out_valid), 64'h2);
        chk($sformatf("bp_data%0d", k), 64'(dat_of(1)),
            64'(((k % 4) << 8) | ((k - 1) / 4)));
      end else begin
        chk($sformatf("bp_valid%0d", k), 64'(out_valid), 64'h0);
      end
    end
    in_valid = '0;
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/xbar_router.md
Name: xbar_router

Overview:
- Crossbar between the PE multiplier array and the accumulator buffer banks of the SCNN accelerator.
- Each of NUM_SRC source ports delivers one product packet (valid, index, data) per cycle into a per-source FIFO.
- Each of NUM_DST destination banks selects at most one FIFO head per cycle, by round-robin, and emits it through a registered output.
- busy gives the PE array backpressure.

Parameters:
- NUM_SRC, 4, number of source (PE) ports.
- NUM_DST, 4, number of destination (accumulator bank) ports; must be a power of two.
- INDEX_W, 8, width of the packet accumulator-address index.
- DATA_W, 16, width of the packet data.
- FIFO_DEPTH, 4, entries per source FIFO; must be a power of two, at least 2.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  NUM_SRC  per-source packet valid.
- in_index  in  NUM_SRC*INDEX_W  per-source index; source s occupies bits [s*INDEX_W +: INDEX_W].
- in_data  in  NUM_SRC*DATA_W  per-source data, packed the same way.
- busy  out  1  backpressure to the PE array; inputs are ignored while busy is high.
- out_valid  out  NUM_DST  per-destination packet valid (registered).
- out_index  out  NUM_DST*INDEX_W  full index of the emitted packet (registered).
- out_data  out  NUM_DST*DATA_W  data of the emitted packet (registered).

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high.
- Destination of a packet: dst = index[log2(NUM_DST)-1:0]. The full index passes through unchanged.
- Source FIFO state: rd_ptr[s] and wt_ptr[s], each log2(FIFO_DEPTH)+1 bits with a wrap bit.
  - Empty: pointers equal.
  - Full: low bits equal and wrap bits differ.
  - Pointers wrap modulo 2*FIFO_DEPTH.
- busy is combinational from current state: busy = OR over s of full[s].
- Write rule, on the rising edge with busy=0:
  - Each source with in_valid[s]=1 writes to its FIFO and wt_ptr[s] increments.
  - in_valid=0 writes nothing.
  - With busy=1, all inputs from all sources are dropped that cycle, so a PE batch is never split.
- Arbitration, per destination d, each cycle:
  - Candidates are non-empty FIFOs whose head index maps to d.
  - Scan starts at rr[d] and goes upward modulo NUM_SRC; the first candidate wins.
  - On a grant to s, rr[d] becomes (s+1) mod NUM_SRC; with no grant, rr[d] holds.
- A FIFO head can map to only one destination, so at most one pop per FIFO per cycle.
- A granted FIFO pops (rd_ptr[s] increments) on the edge.
- On that same edge, out_valid[d]=1 and out_index/out_data[d] load the head contents.
- An ungranted destination gets out_valid[d]=0; its index/data hold their old values.
- A write and a pop on the same FIFO in the same cycle are both performed.
- A packet written on the write cycle is not visible to arbitration until the next cycle. Minimum latency is 2 rising edges from input to out_valid:
  - edge N: write;
  - edge N+1: output register loads;
  - the packet is visible after edge N+1.
- Conflicts: k packets to the same bank from k different sources exit over k consecutive cycles, in round-robin order.
- Packets from one source keep FIFO order, even when they target different banks. A blocked head (its bank granted elsewhere) stalls its FIFO (head-of-line blocking is accepted).
- Reset:
  - all rd_ptr/wt_ptr = 0 and all rr = 0;
  - out_valid = 0, out_index = 0, out_data = 0;
  - busy = 0 after reset.
- Reset mid-operation discards all FIFO contents. There is no flush of in-flight packets.

Optional Feature:
- Macro XBAR_DRAIN_BUSY_EN.
- When defined: busy = any FIFO full OR any FIFO non-empty OR any out_valid bit set. A new batch is accepted only once the crossbar has fully drained, so a PE can poll busy low as "all products delivered".
- When undefined: busy = any FIFO full only (full-throughput mode).

Test Plan:
- Reset: assert reset for one cycle -> out_valid=0000, busy=0, all pointers 0.
- Conflict-free: sources 0..3 send index=0,1,2,3 with data=10,20,30,40 -> after 2 edges, out_valid=1111 and port d carries data=10*(d+1), index=d, for one cycle only.
- Full conflict: all 4 sources send index=4 (bank 0), data=1..4 -> bank 0 emits data 1,2,3,4 on 4 consecutive cycles; rr[0] ends at 0; the other banks stay invalid.
- Round-robin fairness: sources 1 and 2 target bank 3 every cycle (busy=0 sustained) -> bank 3 alternates between sources 1 and 2 with no starvation.
- Backpressure: source 0 sends 4 packets to bank 1 while sources 1..3 continuously hog bank 1, until FIFO 0 is full -> busy=1; a concurrent valid input on source 3 is dropped (never appears); busy falls the cycle after FIFO 0 pops.
- XBAR_DRAIN_BUSY_EN: after one batch, busy stays 1 until the last out_valid cycle completes, then returns to 0; without the macro, busy=0 throughout the same batch.
